// File: rtl/led_sbox_share_compress.sv
// Receiving end of the masked LED S-box CF layer (d=2).
// A first register captures the 36 expanded shares of a nibble and acts as the
// glitch barrier. The next stage XOR-compresses each group of three CF
// instances into one output share per coordinate. A nibble counter labels the
// outputs and pulses round_done after the last nibble of a round.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_cf   36-bit expanded shares, bit [9k+i] = CF i of coord k
//   out_valid/out_ready       handshake for the compressed nibble
//   out_s0/out_s1/out_s2      output shares, bit k = coordinate k
//   nib_idx                   index of the nibble on out_s*
//   round_done                one-cycle pulse after nibble NIBBLES-1 is accepted
module led_sbox_share_compress #(
   parameter int unsigned NIBBLES = 16,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [35:0]      in_cf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_s0,
   output logic [3:0]       out_s1,
   output logic [3:0]       out_s2,
   output logic [CNT_W-1:0] nib_idx,
   output logic             round_done
);

   localparam int unsigned CF_W  = 36;
   localparam int unsigned N_CRD = 4;
   localparam int unsigned CF_PER_CRD = 9;
   localparam int unsigned CF_PER_SH  = 3;

   logic              s1_valid_q, s1_valid_d;
   logic [CF_W-1:0]   s1_cf_q, s1_cf_d;
   logic              s2_valid_q, s2_valid_d;
   logic [N_CRD-1:0]  s2_s0_q, s2_s0_d;
   logic [N_CRD-1:0]  s2_s1_q, s2_s1_d;
   logic [N_CRD-1:0]  s2_s2_q, s2_s2_d;
   logic [CNT_W-1:0]  nib_idx_q, nib_idx_d;
   logic              round_done_q, round_done_d;

   logic              s2_load_c;
   logic              s1_load_c;
   logic              out_xfer_c;
   logic              last_nib_c;
   logic [N_CRD-1:0]  cmp_s0_c, cmp_s1_c, cmp_s2_c;

   // Handshake: S1 may refill in the same cycle it drains into S2.
   always_comb begin
      s2_load_c  = s1_valid_q & (~s2_valid_q | out_ready);
      in_ready   = ~s1_valid_q | s2_load_c;
      s1_load_c  = in_valid & in_ready;
      out_xfer_c = s2_valid_q & out_ready;
      last_nib_c = (nib_idx_q == CNT_W'(NIBBLES - 1));
   end

   // Compression reads only the registered shares; groups never mix across j.
   always_comb begin
      cmp_s0_c = '0;
      cmp_s1_c = '0;
      cmp_s2_c = '0;
      for (int k = 0; k < int'(N_CRD); k++) begin
         cmp_s0_c[k] = ^s1_cf_q[CF_PER_CRD*k                 +: CF_PER_SH];
         cmp_s1_c[k] = ^s1_cf_q[CF_PER_CRD*k + CF_PER_SH     +: CF_PER_SH];
         cmp_s2_c[k] = ^s1_cf_q[CF_PER_CRD*k + 2*CF_PER_SH   +: CF_PER_SH];
      end
   end

   // Next-state for both pipeline stages and the nibble counter.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_cf_d      = s1_cf_q;
      s2_valid_d   = s2_valid_q;
      s2_s0_d      = s2_s0_q;
      s2_s1_d      = s2_s1_q;
      s2_s2_d      = s2_s2_q;
      nib_idx_d    = nib_idx_q;
      round_done_d = 1'b0;

      if (s1_load_c) begin
         s1_valid_d = 1'b1;
         s1_cf_d    = in_cf;
      end else if (s2_load_c) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load_c) begin
         s2_valid_d = 1'b1;
         s2_s0_d    = cmp_s0_c;
         s2_s1_d    = cmp_s1_c;
         s2_s2_d    = cmp_s2_c;
      end else if (out_xfer_c) begin
         s2_valid_d = 1'b0;
      end

      if (out_xfer_c) begin
         nib_idx_d    = last_nib_c ? '0 : nib_idx_q + CNT_W'(1);
         round_done_d = last_nib_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_cf_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_s0_q      <= '0;
         s2_s1_q      <= '0;
         s2_s2_q      <= '0;
         nib_idx_q    <= '0;
         round_done_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_cf_q      <= s1_cf_d;
         s2_valid_q   <= s2_valid_d;
         s2_s0_q      <= s2_s0_d;
         s2_s1_q      <= s2_s1_d;
         s2_s2_q      <= s2_s2_d;
         nib_idx_q    <= nib_idx_d;
         round_done_q <= round_done_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_s0     = s2_s0_q;
   assign out_s1     = s2_s1_q;
   assign out_s2     = s2_s2_q;
   assign nib_idx    = nib_idx_q;
   assign round_done = round_done_q;

endmodule
